// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-DMA controller and bus arbiter that sits between the 2A03 CPU core
// and the shared 64 KiB memory bus.
//
// A CPU write to DMA_REG_ADDR latches a source page byte. The controller then
// halts the CPU (cpu_rdy = 0), takes the bus, and copies $PP00-$PPFF to the
// PPU OAMDATA port (OAM_DATA_ADDR) as 256 read/write pairs. When the copy is
// done it hands the bus back. Outside a DMA the CPU bus passes straight
// through to memory.
//
// Build option:
//   OAM_DMA_ALIGN_EN - when defined, a free-running parity flop and the ALIGN
//                      state are built. An extra dummy cycle is inserted so
//                      that every READ lands on an even cycle (halt length
//                      513 or 514). When undefined, HALT always goes straight
//                      to READ and the halt length is always 513.
//
// Parameters:
//   DMA_REG_ADDR   CPU write address that triggers a DMA (default $4014)
//   OAM_DATA_ADDR  destination address of every DMA write (default $2004)
//
// Ports:
//   clock       in   system/CPU clock, rising-edge active
//   reset       in   synchronous active-high reset, forces IDLE
//   cpu_addr    in   [15:0] CPU address
//   cpu_rw      in   CPU read/write (1 = read)
//   cpu_wdata   in   [7:0] CPU write data
//   cpu_rdy     out  0 halts the CPU
//   bus_addr    out  [15:0] memory address
//   bus_rw      out  memory read/write (1 = read)
//   bus_wdata   out  [7:0] memory write data
//   bus_rdata   in   [7:0] memory read data
//   dma_active  out  1 while the controller owns the bus (READ/WRITE)
//
// State table:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | bus is a pass-through of the CPU; watching for the trigger
//   ST_HALT  | CPU halted, one dummy cycle with a forced read on the bus
//   ST_ALIGN | optional dummy cycle so READ starts on an even cycle
//   ST_READ  | read source byte {page, idx}
//   ST_WRITE | write captured byte to OAMDATA, advance idx
// ---------------------------------------------------------------------------

module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_rdy,
   output logic [15:0] bus_addr,
   output logic        bus_rw,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   output logic        dma_active
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   state_t      state;
   logic [7:0]  page;
   logic [7:0]  idx;
   logic [7:0]  byte_q;
   logic        rdy_q;
   logic        active_q;
   logic        trigger;

`ifdef OAM_DMA_ALIGN_EN
   // Cycle parity: 0 during an even cycle. Free-running from reset.
   logic        odd;
`endif

   assign trigger = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);

   // Single state register. cpu_rdy and dma_active are kept as flags that
   // are updated on the same edges the state changes, so they always agree
   // with the state they describe (rdy only in IDLE, active only in
   // READ/WRITE).
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         page     <= 8'h00;
         idx      <= 8'h00;
         byte_q   <= 8'h00;
         rdy_q    <= 1'b1;
         active_q <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
         odd      <= 1'b0;
`endif
      end else begin
`ifdef OAM_DMA_ALIGN_EN
         odd <= ~odd;
`endif
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  page  <= cpu_wdata;
                  idx   <= 8'h00;
                  rdy_q <= 1'b0;
                  state <= ST_HALT;
               end
            end

            ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
               // An even HALT would put READ on an odd cycle; pad by one.
               if (!odd) begin
                  state <= ST_ALIGN;
               end else begin
                  state    <= ST_READ;
                  active_q <= 1'b1;
               end
`else
               state    <= ST_READ;
               active_q <= 1'b1;
`endif
            end

            ST_ALIGN: begin
               state    <= ST_READ;
               active_q <= 1'b1;
            end

            ST_READ: begin
               byte_q <= bus_rdata;
               state  <= ST_WRITE;
            end

            ST_WRITE: begin
               idx <= idx + 8'd1;
               if (idx == 8'hFF) begin
                  state    <= ST_IDLE;
                  rdy_q    <= 1'b1;
                  active_q <= 1'b0;
               end else begin
                  state <= ST_READ;
               end
            end

            default: begin
               state    <= ST_IDLE;
               rdy_q    <= 1'b1;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   // Bus steering. Only state and CPU inputs feed this mux; bus_rdata is
   // captured into byte_q and never reaches an output combinationally.
   always_comb begin
      bus_addr  = cpu_addr;
      bus_rw    = cpu_rw;
      bus_wdata = cpu_wdata;
      case (state)
         ST_HALT, ST_ALIGN: begin
            // CPU is held; make sure its pending cycle cannot write.
            bus_rw = 1'b1;
         end
         ST_READ: begin
            // {page, idx}: no carry out of the page, $FFFF does not wrap to $0000+.
            bus_addr = {page, idx};
            bus_rw   = 1'b1;
         end
         ST_WRITE: begin
            bus_addr  = OAM_DATA_ADDR;
            bus_rw    = 1'b0;
            bus_wdata = byte_q;
         end
         default: begin
            bus_addr  = cpu_addr;
            bus_rw    = cpu_rw;
            bus_wdata = cpu_wdata;
         end
      endcase
   end

   assign cpu_rdy    = rdy_q;
   assign dma_active = active_q;

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-DMA controller and bus arbiter between `cpu_2a03` and the shared 64 KiB memory/bus.
- Snoops CPU writes to $4014 and latches the page byte.
- Halts the CPU through `cpu_rdy` and takes ownership of the bus.
- Performs 256 read/write pairs, copying $XX00–$XXFF to the PPU OAMDATA port at $2004.
- Returns the bus to the CPU when the copy is complete.
- Outside DMA it is a transparent pass-through of the CPU bus.

## Interface

Parameters:
- `DMA_REG_ADDR`, default 16'h4014: CPU write address that triggers DMA.
- `OAM_DATA_ADDR`, default 16'h2004: destination address for every DMA write.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1: system/CPU clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high; forces IDLE.
- `cpu_addr`  in  16: CPU address bus.
- `cpu_rw`  in  1: CPU read/write (1 = read, 0 = write).
- `cpu_wdata`  in  8: CPU write data.
- `cpu_rdy`  out  1: 0 halts the CPU; the CPU holds its current read cycle.
- `bus_addr`  out  16: address to memory.
- `bus_rw`  out  1: read/write to memory.
- `bus_wdata`  out  8: write data to memory.
- `bus_rdata`  in  8: memory read data, valid before the rising edge ending a read cycle.
- `dma_active`  out  1: 1 while the controller owns the bus.

## Operation

State machine: IDLE, HALT, ALIGN, READ, WRITE.

- **Parity flop `odd`**
  - Reset value 0; toggles every clock.
  - A cycle is "even" when `odd` = 0 during it.
- **IDLE**
  - Trigger: `cpu_rw` = 0 and `cpu_addr` == `DMA_REG_ADDR`.
  - On trigger, latch `page` <= `cpu_wdata`, clear `idx` <= 0, go to HALT.
- **HALT**
  - One dummy cycle.
  - Next state is ALIGN if this cycle is even, otherwise READ. This guarantees READ always lands on an even cycle.
- **ALIGN**
  - One dummy cycle, then READ.
- **READ**
  - Bus driven as `bus_addr` = {`page`, `idx`}, `bus_rw` = 1.
  - `byte_q` <= `bus_rdata` at the end of the cycle; go to WRITE.
- **WRITE**
  - Bus driven as `bus_addr` = `OAM_DATA_ADDR`, `bus_rw` = 0, `bus_wdata` = `byte_q`.
  - `idx` <= `idx` + 1 (8-bit, wraps).
  - If `idx` was 8'hFF, go to IDLE; otherwise go to READ.
- **Outputs during HALT and ALIGN**
  - `bus_addr` = `cpu_addr`, `bus_rw` = 1 (forced read), `bus_wdata` = `cpu_wdata`.
- **Outputs during IDLE**
  - `bus_*` = `cpu_*` combinationally.
- **Status outputs**
  - `cpu_rdy` = 1 only in IDLE.
  - `dma_active` = 1 in READ and WRITE only.
- **Page wrap**
  - Address is {`page`, `idx`}, so page $FF reads $FF00–$FFFF with no carry into a next page.
- **$4014 writes during DMA**
  - Cannot occur, because the CPU is halted.
  - Any write seen outside IDLE is ignored.
- **Reset**
  - Asserting `reset` in any state returns to IDLE on that edge.
  - Clears `page`, `idx`, `byte_q` and `odd`.
  - No further DMA writes are issued; a partially copied OAM stays as written.
- **Reset values**
  - `cpu_rdy` = 1, `dma_active` = 0.
  - `bus_*` follows `cpu_*`.

## Timing

- **Trigger to halt:** the trigger write completes in cycle T; `cpu_rdy` = 0 from cycle T+1 (HALT).
- **Halt length:** 513 cycles (HALT + 512), or 514 when ALIGN is inserted.
- **Read-to-write latency:** data read in READ cycle n is written in WRITE cycle n+1. Exactly 256 writes to `OAM_DATA_ADDR`, in ascending source order.
- **Bus release:** `cpu_rdy` returns to 1 in the cycle after the final WRITE. The CPU's held read then completes normally.
- **Combinational paths:** `cpu_rdy` and `bus_*` are combinational from state and from the `cpu_*` inputs. There is no combinational path from `bus_rdata` to any output.

## Configuration

- **`OAM_DMA_ALIGN_EN` defined:** the ALIGN state exists. Halt length is 513 or 514 cycles, depending on the parity of the HALT cycle.
- **Undefined:** ALIGN and the parity flop are compiled out. HALT always goes to READ, and the halt length is always 513 cycles.

## Test plan

- **Page $02 copy:** memory $0200+i = i ^ 8'h5A. Write $02 to $4014 with the HALT cycle odd. Expected: `cpu_rdy` low for exactly 513 cycles; 256 writes to $2004 with data 8'h5A, 8'h5B, … 8'hA5 in that order.
- **Align inserted:** same copy, but with the HALT cycle even and `OAM_DMA_ALIGN_EN` defined. Expected: `cpu_rdy` low for exactly 514 cycles; first READ address $0200 on an even cycle.
- **Align compiled out:** with `OAM_DMA_ALIGN_EN` undefined, HALT on an even cycle. Expected: 513 cycles.
- **Page $FF:** page $FF copy. Expected: reads $FF00–$FFFF only, final read $FFFF; no access to $0000.
- **Reset mid-transfer:** assert `reset` for one cycle during the 100th WRITE. Expected: `cpu_rdy` = 1 and `dma_active` = 0 on the next cycle; no further $2004 writes; 99 or 100 writes total.
- **Pass-through:** with no trigger, CPU writes $77 to $4015 then reads $0821. Expected: bus mirrors the CPU exactly, `cpu_rdy` stays 1, no DMA starts.
